slink_rx_unpack: RTL and testbench

Downstream consumer of the serial-link receive path in the `clk_12_5m` domain. It drains the receive FIFO through the `empty`/`rdreq`/`dval` handshake and delimits packets from the SOP/EOP flags. Complete packets go into a two-bank ping-pong buffer that main-control logic reads by address and releases. It also checks framing and length, and optionally a checksum, and counts errors.

---
 rtl/slink_pkg.sv | 22 ++
 rtl/slink_rx_buf_ram.sv | 34 +++
 rtl/slink_rx_unpack.sv | 197 +++++++++++++++++++
 tb/tb_slink_rx_unpack.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slink_pkg.sv
// Shared definitions for the serial-link receive path: word field positions,
// unpacker state encoding and default bank depth.
package slink_pkg;

    localparam int unsigned SOP_BIT           = 17;
    localparam int unsigned EOP_BIT           = 16;
    localparam int unsigned PAYLOAD_W         = 16;
    localparam int unsigned WORD_W            = 18;
    localparam int unsigned MAX_WORDS_DEFAULT = 512;

    typedef enum logic [1:0] {
        StIdle,
        StBody,
        StDrop,
        StDone
    } rx_state_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/slink_rx_buf_ram.sv
// Two-bank packet buffer: simple dual-port RAM addressed by {bank, word},
// one write port and one registered read port.
module slink_rx_buf_ram
    import slink_pkg::*;
#(
    parameter int unsigned MAX_WORDS = MAX_WORDS_DEFAULT,
    parameter int unsigned ADDR_W    = $clog2(MAX_WORDS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [ADDR_W:0]      waddr,
    input  logic [PAYLOAD_W-1:0] wdata,
    input  logic [ADDR_W:0]      raddr,
    output logic [PAYLOAD_W-1:0] rdata
);

    logic [PAYLOAD_W-1:0] mem [2*MAX_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/slink_rx_unpack.sv
// Serial-link receive unpacker: drains the RX FIFO, frames packets into a
// ping-pong buffer for the host. Optional checksum check: SLINK_RX_CHKSUM_EN.
module slink_rx_unpack
    import slink_pkg::*;
#(
    parameter int unsigned MAX_WORDS = MAX_WORDS_DEFAULT,
    parameter int unsigned ADDR_W    = $clog2(MAX_WORDS)
) (
    input  logic                 clk_12_5m,
    input  logic                 rst_12_5m,
    input  logic                 slink_mm_empty,
    input  logic                 slink_mm_dval,
    input  logic [WORD_W-1:0]    slink_mm_data,
    output logic                 mm_slink_rdreq,
    output logic                 pkt_rdy,
    output logic [ADDR_W:0]      pkt_len,
    output logic                 pkt_err,
    input  logic [ADDR_W-1:0]    pkt_rd_addr,
    output logic [PAYLOAD_W-1:0] pkt_rd_data,
    input  logic                 pkt_release,
    output logic [15:0]          err_cnt
);

    localparam logic [ADDR_W:0] MaxCount = (ADDR_W + 1)'(MAX_WORDS);

    rx_state_e            state;
    logic                 wait_dval;
    logic                 wbank;
    logic                 rbank;
    logic [1:0]           bank_full;
    logic [1:0]           bank_err;
    logic [ADDR_W:0]      bank_len [2];
    logic [ADDR_W:0]      count;
    logic                 cur_err;
    logic                 pend;
    logic [WORD_W-1:0]    pend_word;

    logic                 we;
    logic [ADDR_W:0]      waddr;
    logic [PAYLOAD_W-1:0] wdata;

    logic                 accept;
    logic                 in_valid;
    logic [WORD_W-1:0]    in_word;
    logic                 in_sop;
    logic                 in_eop;
    logic [PAYLOAD_W-1:0] in_data;
    logic                 issue;
    logic                 rel;
    logic                 chk_bad;
    logic [ADDR_W:0]      count_inc;

    // Only the cycle right after our own request carries a word we asked for.
    assign accept    = slink_mm_dval && wait_dval;

    // A SOP that cut the previous packet short is replayed from pend_word
    // once the next write bank is free.
    assign in_valid  = pend ? !bank_full[wbank] : accept;
    assign in_word   = pend ? pend_word : slink_mm_data;
    assign in_sop    = in_word[SOP_BIT];
    assign in_eop    = in_word[EOP_BIT];
    assign in_data   = in_word[PAYLOAD_W-1:0];
    assign count_inc = count + 1'b1;

    assign issue = !slink_mm_empty && !mm_slink_rdreq && !wait_dval &&
                   !bank_full[wbank] && (state != StDone) && !pend;

    assign rel = pkt_release && bank_full[rbank];

`ifdef SLINK_RX_CHKSUM_EN
    logic [PAYLOAD_W-1:0] csum;

    always_ff @(posedge clk_12_5m) begin
        if (rst_12_5m) begin
            csum <= '0;
        end else if (state == StIdle && in_valid && in_sop) begin
            csum <= in_data;
        end else if (state == StBody && in_valid && !in_sop) begin
            csum <= csum + in_data;
        end
    end

    // The closing word must equal the sum of every word before it.
    assign chk_bad = (in_data != ((state == StIdle) ? '0 : csum));
`else
    assign chk_bad = 1'b0;
`endif

    always_ff @(posedge clk_12_5m) begin
        if (rst_12_5m) begin
            state          <= StIdle;
            mm_slink_rdreq <= 1'b0;
            wait_dval      <= 1'b0;
            wbank          <= 1'b0;
            rbank          <= 1'b0;
            bank_full      <= '0;
            bank_err       <= '0;
            bank_len[0]    <= '0;
            bank_len[1]    <= '0;
            count          <= '0;
            cur_err        <= 1'b0;
            pend           <= 1'b0;
            pend_word      <= '0;
            we             <= 1'b0;
            waddr          <= '0;
            wdata          <= '0;
            err_cnt        <= '0;
        end else begin
            mm_slink_rdreq <= issue;
            wait_dval      <= mm_slink_rdreq;
            we             <= 1'b0;

            if (rel) begin
                bank_full[rbank] <= 1'b0;
                rbank            <= ~rbank;
            end

            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        pend <= 1'b0;
                        if (in_sop) begin
                            we      <= 1'b1;
                            waddr   <= {wbank, {ADDR_W{1'b0}}};
                            wdata   <= in_data;
                            count   <= (ADDR_W + 1)'(1);
                            cur_err <= in_eop ? chk_bad : 1'b0;
                            state   <= in_eop ? StDone : StBody;
                        end else begin
                            err_cnt <= sat_inc(err_cnt);
                        end
                    end
                end

                StBody: begin
                    if (in_valid) begin
                        if (in_sop) begin
                            pend      <= 1'b1;
                            pend_word <= in_word;
                            cur_err   <= 1'b1;
                            state     <= StDone;
                        end else begin
                            we    <= 1'b1;
                            waddr <= {wbank, count[ADDR_W-1:0]};
                            wdata <= in_data;
                            count <= count_inc;
                            if (in_eop) begin
                                cur_err <= chk_bad;
                                state   <= StDone;
                            end else if (count_inc == MaxCount) begin
                                state <= StDrop;
                            end
                        end
                    end
                end

                StDrop: begin
                    if (in_valid && in_eop) begin
                        err_cnt <= sat_inc(err_cnt);
                        state   <= StIdle;
                    end
                end

                StDone: begin
                    bank_full[wbank] <= 1'b1;
                    bank_len[wbank]  <= count;
                    bank_err[wbank]  <= cur_err;
                    if (cur_err) begin
                        err_cnt <= sat_inc(err_cnt);
                    end
                    wbank <= ~wbank;
                    state <= StIdle;
                end

                default: state <= StIdle;
            endcase
        end
    end

    assign pkt_rdy = bank_full[rbank];
    assign pkt_len = bank_len[rbank];
    assign pkt_err = bank_err[rbank];

    slink_rx_buf_ram #(
        .MAX_WORDS (MAX_WORDS),
        .ADDR_W    (ADDR_W)
    ) u_buf_ram (
        .clk   (clk_12_5m),
        .rst   (rst_12_5m),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr ({rbank, pkt_rd_addr}),
        .rdata (pkt_rd_data)
    );

endmodule

// File: tb/tb_slink_rx_unpack.sv
// Scoreboard bench for slink_rx_unpack: FIFO model feeds words, a packet-level
// reference model predicts published packets, a host monitor reads and checks them.
module tb_slink_rx_unpack;

    localparam int unsigned MAXW = 512;
    localparam int unsigned AW   = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          empty = 1'b1;
    logic          dval = 1'b0;
    logic [17:0]   data = '0;
    logic          rdreq;
    logic          rdy;
    logic [AW:0]   plen;
    logic          perr;
    logic [AW-1:0] raddr = '0;
    logic [15:0]   rdata;
    logic          rel = 1'b0;
    logic [15:0]   ecnt;

    always #5 clk = ~clk;

    slink_rx_unpack #(
        .MAX_WORDS (MAXW),
        .ADDR_W    (AW)
    ) dut (
        .clk_12_5m      (clk),
        .rst_12_5m      (rst),
        .slink_mm_empty (empty),
        .slink_mm_dval  (dval),
        .slink_mm_data  (data),
        .mm_slink_rdreq (rdreq),
        .pkt_rdy        (rdy),
        .pkt_len        (plen),
        .pkt_err        (perr),
        .pkt_rd_addr    (raddr),
        .pkt_rd_data    (rdata),
        .pkt_release    (rel),
        .err_cnt        (ecnt)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [17:0] fifo_q[$];
    int          exp_len_q[$];
    bit          exp_err_q[$];
    logic [15:0] exp_data_q[$];

    // Reference model: 0 = between packets, 1 = collecting, 2 = discarding.
    int          m_state = 0;
    logic [15:0] m_words[$];
    int          m_errs = 0;
    bit          hold = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic bump_err();
        if (m_errs < 65535) m_errs++;
    endtask

    task automatic model_publish(input bit bad);
        exp_len_q.push_back(m_words.size());
        exp_err_q.push_back(bad);
        foreach (m_words[i]) exp_data_q.push_back(m_words[i]);
        if (bad) bump_err();
        m_words.delete();
        m_state = 0;
    endtask

    task automatic model_close_eop();
        bit bad;
        bad = 1'b0;
`ifdef SLINK_RX_CHKSUM_EN
        begin
            logic [15:0] s;
            s = '0;
            for (int i = 0; i < m_words.size() - 1; i++) s += m_words[i];
            bad = (m_words[m_words.size() - 1] != s);
        end
`endif
        model_publish(bad);
    endtask

    task automatic model_word(input logic [17:0] w);
        bit          sop;
        bit          eop;
        logic [15:0] d;
        sop = w[17];
        eop = w[16];
        d   = w[15:0];
        case (m_state)
            0: begin
                if (sop) begin
                    m_words.delete();
                    m_words.push_back(d);
                    if (eop) model_close_eop();
                    else m_state = 1;
                end else begin
                    bump_err();
                end
            end
            1: begin
                if (sop) begin
                    model_publish(1'b1);
                    m_words.push_back(d);
                    if (eop) model_close_eop();
                    else m_state = 1;
                end else begin
                    m_words.push_back(d);
                    if (eop) model_close_eop();
                    else if (m_words.size() == MAXW) begin
                        m_words.delete();
                        m_state = 2;
                    end
                end
            end
            default: begin
                if (eop) begin
                    bump_err();
                    m_state = 0;
                end
            end
        endcase
    endtask

    task automatic push_word(input logic [17:0] w);
        fifo_q.push_back(w);
        model_word(w);
    endtask

    task automatic send_pkt(input int n, input bit corrupt);
        logic [15:0] s;
        logic [15:0] d;
        s = '0;
        for (int i = 0; i < n; i++) begin
            d = 16'($urandom);
`ifdef SLINK_RX_CHKSUM_EN
            if (i == n - 1) d = s;
`endif
            if (corrupt && i == n - 1) d = d ^ 16'h0001;
            s += d;
            push_word({(i == 0), (i == n - 1), d});
        end
    endtask

    task automatic wait_idle();
        int quiet;
        int t;
        quiet = 0;
        t = 0;
        while (quiet < 12 && t < 8000) begin
            @(posedge clk);
            #2;
            t++;
            if (fifo_q.size() == 0 && exp_len_q.size() == 0 && rdy === 1'b0 && !dval) quiet++;
            else quiet = 0;
        end
        if (quiet < 12) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout: fifo=%0d pending_pkts=%0d rdy=%b",
                     fifo_q.size(), exp_len_q.size(), rdy);
        end
    endtask

    // Receive FIFO model: a request seen in one cycle yields dval in the next.
    initial begin
        logic req;
        forever begin
            @(negedge clk);
            req = rdreq;
            @(posedge clk);
            #1;
            if (req && fifo_q.size() > 0) begin
                dval = 1'b1;
                data = fifo_q.pop_front();
            end else begin
                dval = 1'b0;
            end
            empty = (fifo_q.size() == 0);
        end
    end

    // Host-side monitor: pops the expected packet whenever one is published.
    initial begin
        int n;
        bit e;
        forever begin
            @(negedge clk);
            if (!hold && !rst && rdy === 1'b1) begin
                if (exp_len_q.size() == 0) begin
                    check("pkt_rdy_unexpected", rdy, 0);
                end else begin
                    n = exp_len_q.pop_front();
                    e = exp_err_q.pop_front();
                    check("pkt_len", plen, n);
                    check("pkt_err", perr, e);
                    @(posedge clk);
                    #1;
                    for (int i = 0; i < n; i++) begin
                        raddr = AW'(i);
                        @(posedge clk);
                        #1;
                        check("pkt_rd_data", rdata, exp_data_q.pop_front());
                    end
                end
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1 rel = 1'b1;
                @(posedge clk);
                #1 rel = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdreq", rdreq, 0);
        check("reset_pkt_rdy", rdy, 0);
        check("reset_pkt_len", plen, 0);
        check("reset_pkt_err", perr, 0);
        check("reset_rd_data", rdata, 0);
        check("reset_err_cnt", ecnt, 0);
        rst = 1'b0;

        // Basic 4-word packet.
        push_word({2'b10, 16'h1111});
        push_word({2'b00, 16'h2222});
        push_word({2'b00, 16'h3333});
        push_word({2'b01, 16'h4444});
        wait_idle();
        check("err_cnt_basic", ecnt, m_errs);

        // Three packets with no release: the third must wait in the FIFO.
        hold = 1'b1;
        send_pkt(4, 1'b0);
        send_pkt(4, 1'b0);
        send_pkt(4, 1'b0);
        repeat (150) @(posedge clk);
        #2;
        check("bp_fifo_left", fifo_q.size(), 4);
        check("bp_pkt_rdy", rdy, 1);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (rdreq) seen = 1'b1;
        end
        check("bp_rdreq_held", seen, 0);
        hold = 1'b0;
        wait_idle();
        check("err_cnt_bp", ecnt, m_errs);

        // SOP arriving inside an open packet.
        push_word({2'b10, 16'h0A01});
        push_word({2'b00, 16'h0A02});
        send_pkt(4, 1'b0);
        wait_idle();
        check("err_cnt_sop_mid", ecnt, m_errs);

        // Overflow: MAX_WORDS words without EOP, EOP on the next one.
        for (int i = 0; i <= MAXW; i++) push_word({(i == 0), (i == MAXW), 16'(i)});
        send_pkt(3, 1'b0);
        wait_idle();
        check("err_cnt_overflow", ecnt, m_errs);

`ifdef SLINK_RX_CHKSUM_EN
        push_word({2'b10, 16'h0001});
        push_word({2'b00, 16'h0002});
        push_word({2'b01, 16'h0003});
        push_word({2'b10, 16'h0001});
        push_word({2'b00, 16'h0002});
        push_word({2'b01, 16'h0004});
        wait_idle();
        check("err_cnt_chksum", ecnt, m_errs);
`endif

        // Randomized traffic, including stray words and truncated packets.
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 9))
                0: push_word({2'b00, 16'($urandom)});
                1: begin
                    push_word({2'b10, 16'($urandom)});
                    repeat ($urandom_range(0, 3)) push_word({2'b00, 16'($urandom)});
                end
                default: send_pkt($urandom_range(1, 12), ($urandom_range(0, 4) == 0));
            endcase
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 40)) @(posedge clk);
        end
        send_pkt(2, 1'b0);
        wait_idle();
        check("err_cnt_random", ecnt, m_errs);

        // Reset in the middle of a packet, then a fresh packet.
        push_word({2'b10, 16'hBEEF});
        push_word({2'b00, 16'h1234});
        wait_idle();
        @(posedge clk);
        #1 rst = 1'b1;
        m_state = 0;
        m_words.delete();
        m_errs = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mid_rdreq", rdreq, 0);
        check("rst_mid_pkt_rdy", rdy, 0);
        check("rst_mid_pkt_len", plen, 0);
        check("rst_mid_pkt_err", perr, 0);
        check("rst_mid_rd_data", rdata, 0);
        check("rst_mid_err_cnt", ecnt, 0);
        rst = 1'b0;
        send_pkt(5, 1'b0);
        wait_idle();
        check("err_cnt_after_reset", ecnt, m_errs);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
